// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS decode constants and encodings
//
// Purpose: opcode constants, ALUOp / ALUSrc encodings shared by decode,
//          ALUctl and aluSrc_mux, register-index width, and the control
//          bundle carried through the ID/EX register.
// Ports:   none (package).
package mips_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  // Opcodes, Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_FUNCT = 4'h2,
    ALU_AND   = 4'h3,
    ALU_OR    = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_LUI   = 4'h6
  } alu_op_e;

  typedef enum logic [3:0] {
    SRC_REG = 4'h0,
    SRC_IMM = 4'h1
  } alu_src_e;

  // Downstream control bits registered in ID/EX
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic branch_ne;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32-entry register file with write-through bypass
//
// Purpose: two asynchronous read ports, one synchronous write port.
//          Register 0 always reads 0 and ignores writes. A write in the
//          same cycle as a read of that register is forwarded to the read.
// Ports:
//   clk            clock, write on rising edge
//   rst            asynchronous active-low clear of all entries
//   rs_addr/rs_data  read port 1
//   rt_addr/rt_data  read port 2
//   we/waddr/wdata   write port
module regfile
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [REG_IDX_W-1:0] rt_addr,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rs_data,
  output logic [WIDTH-1:0]     rt_data
);

  logic [WIDTH-1:0] mem [NUM_REGS];
  logic             wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Bypass takes priority so the instruction in ID sees the value WB is
  // retiring this cycle; r0 is forced to zero after the bypass check.
  always_comb begin
    rs_data = mem[rs_addr];
    if (wr_en && (waddr == rs_addr)) rs_data = wdata;
    if (rs_addr == '0) rs_data = '0;

    rt_data = mem[rt_addr];
    if (wr_en && (waddr == rt_addr)) rt_data = wdata;
    if (rt_addr == '0) rt_data = '0;
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - MIPS instruction-decode stage with ID/EX register
//
// Purpose: decodes Instr, reads rs/rt from the register file, and registers
//          the operands and controls into ID/EX (latency 1). Per edge the
//          priority is Flush (bubble) > Stall (hold) > load.
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   Instr, InstrValid         instruction from IF/ID, 0 = bubble
//   Stall, Flush              ID/EX hold / bubble control
//   WB_RegWrite/WriteReg/WriteData   register-file write-back
//   ALUSrc, ALUOp, Immediate, Reg1, Reg2   operand fields to exe
//   WriteReg                  destination register index
//   RegWrite, MemRead, MemWrite, MemtoReg, Branch, BranchNe  controls
//   Illegal                   unsupported opcode loaded this cycle
//   Valid                     ID/EX holds a real instruction
module decode
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          Instr,
  input  logic                 InstrValid,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic                 WB_RegWrite,
  input  logic [REG_IDX_W-1:0] WB_WriteReg,
  input  logic [WIDTH-1:0]     WB_WriteData,
  output logic [3:0]           ALUSrc,
  output logic [3:0]           ALUOp,
  output logic [15:0]          Immediate,
  output logic [WIDTH-1:0]     Reg1,
  output logic [WIDTH-1:0]     Reg2,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 Branch,
  output logic                 BranchNe,
  output logic                 Illegal,
  output logic                 Valid
);

  // Instruction fields
  logic [5:0]           opcode;
  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  logic [REG_IDX_W-1:0] rd;
  logic [15:0]          imm;

  assign opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rt     = Instr[20:16];
  assign rd     = Instr[15:11];
  assign imm    = Instr[15:0];

  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;

  regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs),
    .rt_addr (rt),
    .we      (WB_RegWrite),
    .waddr   (WB_WriteReg),
    .wdata   (WB_WriteData),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  // Next ID/EX contents
  ctrl_t                n_ctrl;
  logic [3:0]           n_alu_src;
  logic [3:0]           n_alu_op;
  logic [15:0]          n_imm;
  logic [WIDTH-1:0]     n_reg1;
  logic [WIDTH-1:0]     n_reg2;
  logic [REG_IDX_W-1:0] n_write_reg;
  logic                 n_illegal;
  logic                 n_valid;

  always_comb begin
    n_ctrl      = CTRL_NONE;
    n_alu_src   = SRC_REG;
    n_alu_op    = ALU_ADD;
    n_write_reg = '0;
    n_illegal   = 1'b0;
    n_valid     = 1'b0;

    if (InstrValid) begin
      n_valid = 1'b1;
      unique case (opcode)
        OP_RTYPE: begin
          n_alu_op           = ALU_FUNCT;
          n_ctrl.reg_write   = 1'b1;
          n_write_reg        = rd;
        end
        OP_LW: begin
          n_alu_src          = SRC_IMM;
          n_ctrl.mem_read    = 1'b1;
          n_ctrl.mem_to_reg  = 1'b1;
          n_ctrl.reg_write   = 1'b1;
          n_write_reg        = rt;
        end
        OP_SW: begin
          n_alu_src          = SRC_IMM;
          n_ctrl.mem_write   = 1'b1;
        end
        OP_BEQ: begin
          n_alu_op           = ALU_SUB;
          n_ctrl.branch      = 1'b1;
        end
        OP_BNE: begin
          n_alu_op           = ALU_SUB;
          n_ctrl.branch      = 1'b1;
          n_ctrl.branch_ne   = 1'b1;
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
          n_alu_src          = SRC_IMM;
          n_ctrl.reg_write   = 1'b1;
          n_write_reg        = rt;
          case (opcode)
            OP_ANDI: n_alu_op = ALU_AND;
            OP_ORI:  n_alu_op = ALU_OR;
            OP_SLTI: n_alu_op = ALU_SLT;
            OP_LUI:  n_alu_op = ALU_LUI;
            default: n_alu_op = ALU_ADD;
          endcase
        end
        default: begin
          n_valid   = 1'b0;
          n_illegal = 1'b1;
        end
      endcase
    end

    // Data fields of a bubble or illegal instruction are zeroed so the
    // ID/EX register never carries stale operands into exe.
    n_imm  = n_valid ? imm     : '0;
    n_reg1 = n_valid ? rs_data : '0;
    n_reg2 = n_valid ? rt_data : '0;
  end

  // ID/EX register
  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q    <= CTRL_NONE;
      ALUSrc    <= '0;
      ALUOp     <= '0;
      Immediate <= '0;
      Reg1      <= '0;
      Reg2      <= '0;
      WriteReg  <= '0;
      Illegal   <= 1'b0;
      Valid     <= 1'b0;
    end else if (Flush) begin
      ctrl_q    <= CTRL_NONE;
      ALUSrc    <= '0;
      ALUOp     <= '0;
      Immediate <= '0;
      Reg1      <= '0;
      Reg2      <= '0;
      WriteReg  <= '0;
      Illegal   <= 1'b0;
      Valid     <= 1'b0;
    end else if (!Stall) begin
      ctrl_q    <= n_ctrl;
      ALUSrc    <= n_alu_src;
      ALUOp     <= n_alu_op;
      Immediate <= n_imm;
      Reg1      <= n_reg1;
      Reg2      <= n_reg2;
      WriteReg  <= n_write_reg;
      Illegal   <= n_illegal;
      Valid     <= n_valid;
    end
  end

  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign Branch   = ctrl_q.branch;
  assign BranchNe = ctrl_q.branch_ne;

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the 5-stage MIPS pipeline; the producer that drives every operand and control input of `exe`. Decodes a 32-bit instruction, reads two operands from an internal 32-entry register file (written back from the WB stage), and registers the result into the ID/EX pipeline register with stall and flush control. Output latency is one cycle from instruction present to ID/EX valid.

## Interface
- WIDTH, 32, datapath and register width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- Instr  input  32  instruction from IF/ID
- InstrValid  input  1  Instr is a real instruction (0 = bubble)
- Stall  input  1  hold ID/EX contents
- Flush  input  1  load a bubble into ID/EX
- WB_RegWrite  input  1  write-back enable
- WB_WriteReg  input  5  write-back register index
- WB_WriteData  input  WIDTH  write-back data
- ALUSrc  output  4  to exe; 4'h0 = Reg2, 4'h1 = sign-extended immediate
- ALUOp  output  4  to exe; encoding below
- Immediate  output  16  Instr[15:0] (carries funct for R-type)
- Reg1, Reg2  output  WIDTH  rs and rt data
- WriteReg  output  5  destination: rd for R-type, rt otherwise, 0 for sw/beq/bne
- RegWrite, MemRead, MemWrite, MemtoReg, Branch, BranchNe  output  1 each  downstream controls
- Illegal  output  1  unsupported opcode seen
- Valid  output  1  ID/EX holds a real instruction

## Operation
- ALUOp: 4'h0 ADD (lw, sw, addi), 4'h1 SUB (beq, bne), 4'h2 FUNCT (R-type, decoded downstream from Immediate[5:0]), 4'h3 AND (andi), 4'h4 OR (ori), 4'h5 SLT (slti), 4'h6 LUI.
- Opcode decode (Instr[31:26]):
  - 6'h00 R-type: ALUSrc 0, RegWrite 1.
  - 6'h23 lw: ALUSrc 1, MemRead 1, MemtoReg 1, RegWrite 1.
  - 6'h2B sw: ALUSrc 1, MemWrite 1.
  - 6'h04 beq: ALUSrc 0, Branch 1. 6'h05 bne: same plus BranchNe 1.
  - 6'h08 addi, 6'h0C andi, 6'h0D ori, 6'h0A slti, 6'h0F lui: ALUSrc 1, RegWrite 1.
- Any other opcode: all controls 0, Valid 0, Illegal 1.
- Register file: 32 × WIDTH. Register 0 reads 0; writes to it are ignored. Write on rising edge when WB_RegWrite = 1.
- Write-through bypass: if WB_RegWrite and WB_WriteReg (≠ 0) equals rs or rt in the same cycle, the read returns WB_WriteData.
- InstrValid = 0: ID/EX loads a bubble.
  - Bubble: all controls, WriteReg, Illegal and Valid = 0.
  - Data fields (ALUSrc, ALUOp, Immediate, Reg1, Reg2) are don't-care; a bubble loads 0 into them.

## Timing
- Reset (rst low, asynchronous): every output 0 and every register-file entry 0. Held until the first rising edge after rst goes high.
- Latency 1: Instr is sampled at edge N, and outputs are valid after edge N.
- Priority per edge: Flush > Stall > load.
  - Flush loads a bubble even when Stall = 1.
  - Stall alone holds all outputs bit-exact.
- The register file writes on every edge with WB_RegWrite, regardless of Stall or Flush.
- Outputs held by Stall are not refreshed by a later WB write. The hazard unit is responsible for that case.
- Illegal is registered. It asserts for exactly one cycle per illegal instruction loaded, and is held under Stall.
- Reset asserted mid-operation: outputs clear immediately without waiting for clk. The register file also clears.

## Structure
- Package `mips_pkg` holds:
  - opcode constants;
  - ALUOp and ALUSrc encodings (shared with ALUctl and aluSrc_mux);
  - the register-index width (5).
- Sub-module `regfile`:
  - 2 asynchronous read ports and 1 synchronous write port;
  - write-through bypass and the r0 rule;
  - asynchronous clear.
- `decode` contains the combinational control decoder and the ID/EX register.

## Test plan
- Reset, then a WB write of 32'hDEADBEEF to r5, then add r3, r5, r5 (32'h00A51820) → next cycle: Reg1 = Reg2 = 32'hDEADBEEF, ALUOp = 2, ALUSrc = 0, WriteReg = 3, RegWrite = 1, Valid = 1.
- lw r8, -4(r2) (32'h8C48FFFC) → ALUSrc = 1, ALUOp = 0, Immediate = 16'hFFFC, MemRead = MemtoReg = RegWrite = 1, WriteReg = 8.
- Same-cycle bypass: WB writes 32'h12345678 to r7 while decoding sw r7, 0(r7) → Reg1 = Reg2 = 32'h12345678, MemWrite = 1, WriteReg = 0.
- Edge cases:
  - WB write of 32'hFFFFFFFF to r0, then addi r1, r0, 5 → Reg1 = 0, Immediate = 5.
  - Opcode 6'h3F → Illegal = 1 for one cycle, Valid = 0.
- Control priority:
  - Stall for 3 cycles with a changing Instr → outputs unchanged.
  - Stall + Flush together → bubble.
- Assert rst low mid-stream, between edges → all outputs 0 immediately; after release, a read of r5 returns 0.
